rv32i_lsu: RTL and testbench

- Load/store unit forming the memory stage directly downstream of decode/execute.
- Consumes the control_t memory fields (mem_read, mem_write, mem_funct3) plus the execute-computed address and store data.
- Drives a req/gnt/rvalid data-memory bus and returns aligned, sign/zero-extended load data to writeback.
- Stalls the pipeline while an access is outstanding.

---
 rtl/rv32i_lsu.sv | 204 ++++++++++++++++++++
 tb/tb_rv32i_lsu.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: req/gnt/rvalid data bus, load extension, bus timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module rv32i_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_mem_write_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_rd_i,
  output logic        lsu_stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_rdata_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic [31:0] err_addr_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  localparam logic [1:0] CauseFunct3   = 2'd0;
  localparam logic [1:0] CauseMisalign = 2'd1;
  localparam logic [1:0] CauseTimeout  = 2'd2;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     addr_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [1:0]      eff_lo_q;

  logic        accept;
  logic        f3_ok;
  logic        mis_err;
  logic [1:0]  size;
  logic [1:0]  eff_lo;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        busy;
  logic        timeout;
  logic        done_store;
  logic        done_load;
  logic        gnt_load;
  logic        abort;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign size   = ex_funct3_i[1:0];
  assign accept = (state_q == StIdle) & ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
  assign f3_ok  = ex_mem_write_i ? (ex_funct3_i inside {3'b000, 3'b001, 3'b010})
                                 : (ex_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_err = ((size == 2'b01) & ex_addr_i[0]) | ((size == 2'b10) & (|ex_addr_i[1:0]));
`else
  assign mis_err = 1'b0;
`endif

  // Byte offset actually used: bits below the access size are dropped.
  always_comb begin
    eff_lo = ex_addr_i[1:0];
    case (size)
      2'b01:   eff_lo = {ex_addr_i[1], 1'b0};
      2'b10:   eff_lo = 2'b00;
      default: ;
    endcase
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_wdata_i;
    if (ex_mem_write_i) begin
      case (size)
        2'b00: begin
          st_be    = 4'b0001 << eff_lo;
          st_wdata = {4{ex_wdata_i[7:0]}};
        end
        2'b01: begin
          st_be    = 4'b0011 << eff_lo;
          st_wdata = {2{ex_wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q != StIdle);
  assign timeout    = busy & (cnt_q >= CntLast);
  assign done_store = (state_q == StReq) & dmem_we_o & dmem_gnt_i;
  assign gnt_load   = (state_q == StReq) & ~dmem_we_o & dmem_gnt_i;
  assign done_load  = (state_q == StWait) & dmem_rvalid_i;
  // A handshake landing on the timeout cycle takes precedence over the abort.
  assign abort      = timeout & ~done_store & ~gnt_load & ~done_load;

  assign lsu_stall_o = (accept & f3_ok & ~mis_err) | (busy & ~done_store & ~done_load & ~abort);

  always_comb begin
    shifted = dmem_rdata_i >> {eff_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      eff_lo_q     <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_rdata_o   <= '0;
      err_o        <= 1'b0;
      err_cause_o  <= '0;
      err_addr_o   <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_be_o    <= '0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      err_o      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (!f3_ok) begin
              err_o       <= 1'b1;
              err_cause_o <= CauseFunct3;
              err_addr_o  <= ex_addr_i;
            end else if (mis_err) begin
              err_o       <= 1'b1;
              err_cause_o <= CauseMisalign;
              err_addr_o  <= ex_addr_i;
            end else begin
              state_q      <= StReq;
              cnt_q        <= '0;
              addr_q       <= ex_addr_i;
              funct3_q     <= ex_funct3_i;
              rd_q         <= ex_rd_i;
              eff_lo_q     <= eff_lo;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= ex_mem_write_i;
              dmem_be_o    <= st_be;
              dmem_addr_o  <= {ex_addr_i[31:2], 2'b00};
              dmem_wdata_o <= st_wdata;
            end
          end
        end
        StReq: begin
          cnt_q <= cnt_q + CntW'(1);
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            state_q    <= dmem_we_o ? StIdle : StWait;
          end else if (timeout) begin
            dmem_req_o  <= 1'b0;
            state_q     <= StIdle;
            err_o       <= 1'b1;
            err_cause_o <= CauseTimeout;
            err_addr_o  <= addr_q;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + CntW'(1);
          if (dmem_rvalid_i) begin
            state_q    <= StIdle;
            wb_valid_o <= 1'b1;
            wb_rd_o    <= rd_q;
            wb_rdata_o <= load_data;
          end else if (timeout) begin
            state_q     <= StIdle;
            err_o       <= 1'b1;
            err_cause_o <= CauseTimeout;
            err_addr_o  <= addr_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: directed scenarios plus randomized accesses vs a
// byte-lane reference model. Honours LSU_MISALIGN_TRAP_EN.
module tb_rv32i_lsu;

  localparam int unsigned MaxWait = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i, ex_mem_read_i, ex_mem_write_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_addr_i, ex_wdata_i;
  logic [4:0]  ex_rd_i;
  logic        lsu_stall_o, wb_valid_o, err_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_rdata_o, err_addr_o;
  logic [1:0]  err_cause_o;
  logic        dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  // Observations gathered by run_access for the scenario tasks to judge.
  int          o_stall_hi, o_req_cycles, o_wb_count, o_wb_cycle, o_err_count, o_err_cycle;
  bit          o_unstable;
  logic        o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata, o_wb_rdata, o_err_addr;
  logic [4:0]  o_wb_rd;
  logic [1:0]  o_cause;

  rv32i_lsu #(.MAX_WAIT(MaxWait)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid_i    (ex_valid_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_mem_write_i(ex_mem_write_i),
    .ex_funct3_i   (ex_funct3_i),
    .ex_addr_i     (ex_addr_i),
    .ex_wdata_i    (ex_wdata_i),
    .ex_rd_i       (ex_rd_i),
    .lsu_stall_o   (lsu_stall_o),
    .wb_valid_o    (wb_valid_o),
    .wb_rd_o       (wb_rd_o),
    .wb_rdata_o    (wb_rdata_o),
    .err_o         (err_o),
    .err_cause_o   (err_cause_o),
    .err_addr_o    (err_addr_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int unsigned off,
                                           input logic [31:0] rdata);
    int unsigned n = 1 << f3[1:0];
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    logic [31:0] v = (rdata >> (8 * off)) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input int unsigned off);
    int unsigned n = 1 << f3[1:0];
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (f3[1:0] == 2'b01) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  // Drives one access and a simple bus: gnt on REQ cycle gd (0-based), rvalid rv cycles after
  // gnt (rv=0: never). Cycle 0 is the accept cycle.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd, input int gd,
                            input int rv, input logic [31:0] rdata);
    bit wait_phase = 0;
    int wait_k = 0;
    int req_seen = 0;
    @(negedge clk);
    ex_valid_i = 1'b1; ex_mem_read_i = ~we; ex_mem_write_i = we;
    ex_funct3_i = f3; ex_addr_i = addr; ex_wdata_i = wdata; ex_rd_i = rd;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    #1;
    o_stall_hi = lsu_stall_o ? 1 : 0;
    o_req_cycles = 0; o_unstable = 0; o_wb_count = 0; o_wb_cycle = -1;
    o_err_count = 0; o_err_cycle = -1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      ex_valid_i = 1'b0; ex_mem_read_i = 1'b0; ex_mem_write_i = 1'b0;
      ex_addr_i = $urandom; ex_wdata_i = $urandom;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
      if (wait_phase && rv > 0 && wait_k == rv) begin
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
      end
      if (dmem_req_o) begin
        if (req_seen == 0) begin
          o_addr = dmem_addr_o; o_be = dmem_be_o; o_wdata = dmem_wdata_o; o_we = dmem_we_o;
        end else if (dmem_addr_o !== o_addr || dmem_be_o !== o_be ||
                     dmem_wdata_o !== o_wdata || dmem_we_o !== o_we) begin
          o_unstable = 1;
        end
        if (req_seen == gd) dmem_gnt_i = 1'b1;
        req_seen++;
        o_req_cycles++;
      end
      #1;
      if (lsu_stall_o) o_stall_hi++;
      if (wb_valid_o) begin
        o_wb_count++;
        if (o_wb_cycle < 0) begin o_wb_cycle = c; o_wb_rd = wb_rd_o; o_wb_rdata = wb_rdata_o; end
      end
      if (err_o) begin
        o_err_count++;
        if (o_err_cycle < 0) begin o_err_cycle = c; o_cause = err_cause_o; o_err_addr = err_addr_o; end
      end
      if (dmem_rvalid_i) wait_phase = 0;
      else if (wait_phase) wait_k++;
      if (dmem_gnt_i && !we) begin wait_phase = 1; wait_k = 1; end
    end
    @(negedge clk);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    ex_valid_i = 0; ex_mem_read_i = 0; ex_mem_write_i = 0; ex_funct3_i = 0;
    ex_addr_i = 0; ex_wdata_i = 0; ex_rd_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    #3 rst_n = 1'b0;
    #4;
    n_checks++;
    if ({lsu_stall_o, wb_valid_o, wb_rd_o, wb_rdata_o, err_o, err_cause_o, err_addr_o,
         dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got req=%b stall=%b be=%h addr=%h required all zero",
               dmem_req_o, lsu_stall_o, dmem_be_o, dmem_addr_o);
    end
    @(negedge clk); rst_n = 1'b1;
    // ex_valid without read/write must not start anything
    @(negedge clk); ex_valid_i = 1'b1; ex_funct3_i = 3'b010;
    #1;
    n_checks++;
    if (lsu_stall_o !== 1'b0) begin
      n_errors++; $display("FAIL noop_stall: got %b required 0", lsu_stall_o);
    end
    @(negedge clk); ex_valid_i = 1'b0;
    n_checks++;
    if (dmem_req_o !== 1'b0 || err_o !== 1'b0) begin
      n_errors++; $display("FAIL noop_req: got req=%b err=%b required 0 0", dmem_req_o, err_o);
    end
  endtask

  task automatic test_store_sb();
    run_access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd0, 0, 0, 32'd0);
    n_checks++;
    if (o_addr !== 32'h0000_1000 || o_be !== 4'b1000 || o_we !== 1'b1) begin
      n_errors++;
      $display("FAIL sb_bus: got addr=%h be=%b we=%b required 00001000 1000 1", o_addr, o_be, o_we);
    end
    n_checks++;
    if (o_wdata !== 32'hABAB_ABAB) begin
      n_errors++; $display("FAIL sb_wdata: got %h required abababab", o_wdata);
    end
    n_checks++;
    if (o_stall_hi !== 1 || o_req_cycles !== 1) begin
      n_errors++;
      $display("FAIL sb_stall: got stall_cycles=%0d req_cycles=%0d required 1 1",
               o_stall_hi, o_req_cycles);
    end
    n_checks++;
    if (o_wb_count !== 0 || o_err_count !== 0) begin
      n_errors++; $display("FAIL sb_nowb: got wb=%0d err=%0d required 0 0", o_wb_count, o_err_count);
    end
  endtask

  task automatic test_load_lh();
    run_access(1'b0, 3'b001, 32'h0000_2002, 32'd0, 5'd5, 0, 2, 32'h8001_1234);
    n_checks++;
    if (o_wb_count !== 1 || o_wb_rd !== 5'd5 || o_wb_rdata !== 32'hFFFF_8001) begin
      n_errors++;
      $display("FAIL lh_wb: got n=%0d rd=%0d data=%h required 1 5 ffff8001",
               o_wb_count, o_wb_rd, o_wb_rdata);
    end
    n_checks++;
    if (o_wb_cycle !== 4 || o_stall_hi !== 3 || o_be !== 4'b1111 || o_addr !== 32'h0000_2000) begin
      n_errors++;
      $display("FAIL lh_timing: got wb_cycle=%0d stall=%0d be=%b addr=%h required 4 3 1111 00002000",
               o_wb_cycle, o_stall_hi, o_be, o_addr);
    end
    run_access(1'b0, 3'b101, 32'h0000_2002, 32'd0, 5'd5, 0, 2, 32'h8001_1234);
    n_checks++;
    if (o_wb_count !== 1 || o_wb_rdata !== 32'h0000_8001) begin
      n_errors++;
      $display("FAIL lhu_wb: got n=%0d data=%h required 1 00008001", o_wb_count, o_wb_rdata);
    end
    run_access(1'b0, 3'b010, 32'h0000_2004, 32'd0, 5'd0, 1, 1, 32'h1234_5678);
    n_checks++;
    if (o_wb_count !== 1 || o_wb_rd !== 5'd0 || o_wb_rdata !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL lw_rd0: got n=%0d rd=%0d data=%h required 1 0 12345678",
               o_wb_count, o_wb_rd, o_wb_rdata);
    end
  endtask

  task automatic test_gnt_delay();
    run_access(1'b0, 3'b000, 32'h0000_2001, 32'd0, 5'd3, 3, 1, 32'h0000_F700);
    n_checks++;
    if (o_req_cycles !== 4 || o_unstable !== 1'b0) begin
      n_errors++;
      $display("FAIL lb_req_hold: got req_cycles=%0d unstable=%b required 4 0",
               o_req_cycles, o_unstable);
    end
    n_checks++;
    if (o_wb_rdata !== 32'hFFFF_FFF7 || o_wb_count !== 1) begin
      n_errors++; $display("FAIL lb_data: got %h n=%0d required fffffff7 1", o_wb_rdata, o_wb_count);
    end
  endtask

  task automatic test_timeout();
    // rvalid never comes
    run_access(1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd9, 0, 0, 32'd0);
    n_checks++;
    if (o_err_count !== 1 || o_cause !== 2'd2 || o_err_addr !== 32'h0000_5000) begin
      n_errors++;
      $display("FAIL to_wait_err: got n=%0d cause=%0d addr=%h required 1 2 00005000",
               o_err_count, o_cause, o_err_addr);
    end
    n_checks++;
    if (o_err_cycle !== MaxWait + 1 || o_stall_hi !== MaxWait || o_wb_count !== 0) begin
      n_errors++;
      $display("FAIL to_wait_timing: got err_cycle=%0d stall=%0d wb=%0d required %0d %0d 0",
               o_err_cycle, o_stall_hi, o_wb_count, MaxWait + 1, MaxWait);
    end
    // gnt never comes: req must drop after MaxWait REQ cycles
    run_access(1'b1, 3'b010, 32'h0000_5010, 32'h1111_2222, 5'd0, 1000, 0, 32'd0);
    n_checks++;
    if (o_req_cycles !== MaxWait || o_err_cycle !== MaxWait + 1 || o_cause !== 2'd2) begin
      n_errors++;
      $display("FAIL to_req: got req_cycles=%0d err_cycle=%0d cause=%0d required %0d %0d 2",
               o_req_cycles, o_err_cycle, o_cause, MaxWait, MaxWait + 1);
    end
    run_access(1'b0, 3'b010, 32'h0000_5020, 32'd0, 5'd4, 0, 1, 32'hCAFE_F00D);
    n_checks++;
    if (o_wb_count !== 1 || o_wb_rdata !== 32'hCAFE_F00D || o_err_count !== 0) begin
      n_errors++;
      $display("FAIL to_recover: got wb=%0d data=%h err=%0d required 1 cafef00d 0",
               o_wb_count, o_wb_rdata, o_err_count);
    end
  endtask

  task automatic test_misalign();
    run_access(1'b0, 3'b010, 32'h0000_3001, 32'd0, 5'd6, 0, 1, 32'hDEAD_BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++;
    if (o_err_count !== 1 || o_err_cycle !== 1 || o_cause !== 2'd1 ||
        o_err_addr !== 32'h0000_3001) begin
      n_errors++;
      $display("FAIL mis_trap: got n=%0d cyc=%0d cause=%0d addr=%h required 1 1 1 00003001",
               o_err_count, o_err_cycle, o_cause, o_err_addr);
    end
    n_checks++;
    if (o_req_cycles !== 0 || o_wb_count !== 0) begin
      n_errors++;
      $display("FAIL mis_nobus: got req=%0d wb=%0d required 0 0", o_req_cycles, o_wb_count);
    end
`else
    n_checks++;
    if (o_addr !== 32'h0000_3000 || o_wb_count !== 1 || o_wb_rdata !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL mis_align: got addr=%h wb=%0d data=%h required 00003000 1 deadbeef",
               o_addr, o_wb_count, o_wb_rdata);
    end
    n_checks++;
    if (o_err_count !== 0) begin
      n_errors++; $display("FAIL mis_noerr: got err=%0d required 0", o_err_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ex_valid_i = 1'b1; ex_mem_read_i = 1'b1; ex_mem_write_i = 1'b0;
    ex_funct3_i = 3'b010; ex_addr_i = 32'h0000_4008; ex_rd_i = 5'd7;
    @(negedge clk);
    ex_valid_i = 1'b0; ex_mem_read_i = 1'b0; dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    #1;
    n_checks++;
    if (lsu_stall_o !== 1'b1 || dmem_addr_o !== 32'h0000_4008) begin
      n_errors++;
      $display("FAIL rst_pre_wait: got stall=%b addr=%h required 1 00004008", lsu_stall_o, dmem_addr_o);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({lsu_stall_o, wb_valid_o, wb_rd_o, wb_rdata_o, err_o, err_cause_o, err_addr_o,
         dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o} !== '0) begin
      n_errors++;
      $display("FAIL rst_mid: got stall=%b be=%h addr=%h required all zero",
               lsu_stall_o, dmem_be_o, dmem_addr_o);
    end
    @(negedge clk); rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        dmem_rvalid_i = (i < 3); dmem_rdata_i = $urandom;
        #1 if (wb_valid_o || err_o || dmem_req_o) seen++;
      end
      dmem_rvalid_i = 1'b0;
      n_checks++;
      if (seen !== 0) begin
        n_errors++; $display("FAIL rst_late_rvalid: got %0d pulses required 0", seen);
      end
    end
  endtask

  task automatic test_bad_funct3();
    run_access(1'b0, 3'b011, 32'h0000_6004, 32'd0, 5'd2, 0, 1, 32'd0);
    n_checks++;
    if (o_err_count !== 1 || o_err_cycle !== 1 || o_cause !== 2'd0 ||
        o_err_addr !== 32'h0000_6004 || o_req_cycles !== 0) begin
      n_errors++;
      $display("FAIL f3_load: got n=%0d cyc=%0d cause=%0d addr=%h req=%0d required 1 1 0 00006004 0",
               o_err_count, o_err_cycle, o_cause, o_err_addr, o_req_cycles);
    end
    run_access(1'b1, 3'b100, 32'h0000_6008, 32'h55, 5'd0, 0, 0, 32'd0);
    n_checks++;
    if (o_err_count !== 1 || o_cause !== 2'd0 || o_req_cycles !== 0) begin
      n_errors++;
      $display("FAIL f3_store: got n=%0d cause=%0d req=%0d required 1 0 0",
               o_err_count, o_cause, o_req_cycles);
    end
  endtask

  task automatic test_random();
    logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 40; i++) begin
      logic        we = 1'($urandom_range(0, 1));
      logic [2:0]  f3 = load_f3[we ? $urandom_range(0, 2) : $urandom_range(0, 4)];
      logic [31:0] addr = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rd_data = $urandom;
      logic [4:0]  rd = 5'($urandom_range(0, 31));
      int          gd = $urandom_range(0, 3);
      int          rv = $urandom_range(1, 3);
      int unsigned n = 1 << f3[1:0];
      int unsigned off = addr % 4;
      bit          exp_trap;
`ifdef LSU_MISALIGN_TRAP_EN
      exp_trap = (addr % n) != 0;
`else
      exp_trap = 1'b0;
`endif
      off = off - (off % n);
      run_access(we, f3, addr, wd, rd, gd, rv, rd_data);
      if (exp_trap) begin
        n_checks++;
        if (o_err_count !== 1 || o_cause !== 2'd1 || o_err_addr !== addr || o_req_cycles !== 0) begin
          n_errors++;
          $display("FAIL rnd_trap[%0d]: got n=%0d cause=%0d addr=%h req=%0d required 1 1 %h 0",
                   i, o_err_count, o_cause, o_err_addr, o_req_cycles, addr);
        end
      end else begin
        n_checks++;
        if (o_addr !== addr - (addr % 4) || o_we !== we || o_req_cycles !== gd + 1 ||
            o_unstable !== 1'b0 || o_err_count !== 0) begin
          n_errors++;
          $display("FAIL rnd_bus[%0d]: got addr=%h we=%b req=%0d unst=%b err=%0d required %h %b %0d 0 0",
                   i, o_addr, o_we, o_req_cycles, o_unstable, o_err_count,
                   addr - (addr % 4), we, gd + 1);
        end
        if (we) begin
          n_checks++;
          if (o_be !== ref_be(f3, off) || o_wdata !== ref_wdata(f3, wd) ||
              o_wb_count !== 0 || o_stall_hi !== gd + 1) begin
            n_errors++;
            $display("FAIL rnd_store[%0d]: got be=%b wd=%h wb=%0d stall=%0d required %b %h 0 %0d",
                     i, o_be, o_wdata, o_wb_count, o_stall_hi, ref_be(f3, off),
                     ref_wdata(f3, wd), gd + 1);
          end
        end else begin
          n_checks++;
          if (o_be !== 4'b1111 || o_wb_count !== 1 || o_wb_rd !== rd ||
              o_wb_rdata !== ref_load(f3, off, rd_data) || o_wb_cycle !== gd + rv + 2 ||
              o_stall_hi !== gd + rv + 1) begin
            n_errors++;
            $display("FAIL rnd_load[%0d]: got be=%b n=%0d rd=%0d data=%h cyc=%0d stall=%0d required 1111 1 %0d %h %0d %0d",
                     i, o_be, o_wb_count, o_wb_rd, o_wb_rdata, o_wb_cycle, o_stall_hi,
                     rd, ref_load(f3, off, rd_data), gd + rv + 2, gd + rv + 1);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_sb();
    test_load_lh();
    test_gnt_delay();
    test_timeout();
    test_misalign();
    test_reset_mid();
    test_bad_funct3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
